// File: rtl/cpu_trace_recorder_if.sv
// rtl/cpu_trace_recorder_if.sv - capture, stream and status signals of the trace recorder
// The recorder takes the master side; the CPU/consumer side takes the slave side.
interface cpu_trace_recorder_if;
  logic        cap_en;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] rec_count;
  logic [15:0] drop_count;
  logic        overflow;
  logic        done;

  modport master (
    input  cap_en, pc, inst, out_ready,
    output out_data, out_valid, out_last, rec_count, drop_count, overflow, done
  );

  modport slave (
    output cap_en, pc, inst, out_ready,
    input  out_data, out_valid, out_last, rec_count, drop_count, overflow, done
  );
endinterface

// File: rtl/cpu_trace_recorder.sv
// rtl/cpu_trace_recorder.sv - buffers (pc, inst) pairs in a FIFO and streams them as 32-bit words
// Each pair leaves as two words: pc first, then inst with out_last set.
module cpu_trace_recorder #(
  parameter int DEPTH       = 8,
  parameter int MAX_RECORDS = 153
) (
  input  logic                 clk_in,
  input  logic                 reset,
  cpu_trace_recorder_if.master bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [15:0] MAX_REC  = 16'(MAX_RECORDS);

  typedef enum logic [1:0] {
    IDLE,
    SEND_PC,
    SEND_INST
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [AW:0]   occ_next;
  logic [15:0]   rec_count;
  logic [15:0]   drop_count;
  logic          overflow;
  logic          done;
  logic          attempt;
  logic          accept;
  logic          drop;
  logic          pop;

  // A full FIFO still accepts when the head pair leaves on the same edge.
  assign pop     = (state == SEND_INST) && bus.out_ready;
  assign attempt = bus.cap_en && !done;
  assign accept  = attempt && ((occ != FULL_OCC) || pop);
  assign drop    = attempt && !accept;

  always_comb begin
    occ_next = occ;
    case ({accept, pop})
      2'b10:   occ_next = occ + (AW+1)'(1);
      2'b01:   occ_next = occ - (AW+1)'(1);
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (accept) begin
      pc_mem[wr_ptr]   <= bus.pc;
      inst_mem[wr_ptr] <= bus.inst;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      rec_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else begin
      occ <= occ_next;
      if (accept) begin
        wr_ptr    <= wr_ptr + 1'b1;
        rec_count <= rec_count + 16'd1;
        if (rec_count + 16'd1 == MAX_REC) begin
          done <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Output words come straight from the head slot, which cannot move until the pop.
  always_comb begin
    state_next    = state;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;
    case (state)
      IDLE: begin
        if (occ != '0) begin
          state_next = SEND_PC;
        end
      end
      SEND_PC: begin
        bus.out_valid = 1'b1;
        bus.out_data  = pc_mem[rd_ptr];
        if (bus.out_ready) begin
          state_next = SEND_INST;
        end
      end
      SEND_INST: begin
        bus.out_valid = 1'b1;
        bus.out_last  = 1'b1;
        bus.out_data  = inst_mem[rd_ptr];
        if (bus.out_ready) begin
          state_next = (occ_next != '0) ? SEND_PC : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.rec_count  = rec_count;
  assign bus.drop_count = drop_count;
  assign bus.overflow   = overflow;
  assign bus.done       = done;

endmodule
